// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/cache types, instruction-cache address layout and FSM states
// Ports: none (package).
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;
    typedef enum logic {IDLE, FILL} icache_state_t;
endpackage

// File: rtl/caches_if.sv
// caches_if: instruction-cache to memory-controller read port
// Ports: iREN/iaddr (cache -> memory), iload/iwait (memory -> cache).
interface caches_if;
    import cpu_types_pkg::*;
    logic  iREN;
    logic  iwait;
    word_t iaddr;
    word_t iload;
    modport icache (output iREN, iaddr, input iload, iwait);
    modport mem (input iREN, iaddr, output iload, iwait);
endinterface

// File: rtl/datapath_cache_if.sv
// datapath_cache_if: fetch-stage to instruction-cache handshake
// Ports: imemREN/imemaddr (datapath -> cache), ihit/imemload (cache -> datapath).
interface datapath_cache_if;
    import cpu_types_pkg::*;
    logic  imemREN;
    logic  ihit;
    word_t imemaddr;
    word_t imemload;
    modport icache (input imemREN, imemaddr, output ihit, imemload);
    modport dp (output imemREN, imemaddr, input ihit, imemload);
endinterface

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with one-word miss fill
// Ports: CLK, nRST (async, active-low); dcif = fetch side (combinational hit);
//        cif = memory fill side (iREN/iaddr out, iload/iwait in).
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input logic              CLK,
    input logic              nRST,
    datapath_cache_if.icache dcif,
    caches_if.icache         cif
);
    localparam int TAG_W = 30 - IDX_W;
    icache_state_t    state_q, state_d;
    word_t            miss_addr_q, miss_addr_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [SETS];
    logic [TAG_W-1:0] tag_d [SETS];
    word_t            data_q [SETS];
    word_t            data_d [SETS];
    logic [TAG_W-1:0] req_tag, miss_tag;
    logic [IDX_W-1:0] req_idx, miss_idx;
    logic             hit;

    assign req_tag  = dcif.imemaddr[31:IDX_W+2];
    assign req_idx  = dcif.imemaddr[IDX_W+1:2];
    assign miss_tag = miss_addr_q[31:IDX_W+2];
    assign miss_idx = miss_addr_q[IDX_W+1:2];
    // No hit is reported while a fill is outstanding, whatever the array holds.
    assign hit = state_q == IDLE && dcif.imemREN && valid_q[req_idx] && tag_q[req_idx] == req_tag;
    assign dcif.ihit     = hit;
    assign dcif.imemload = hit ? data_q[req_idx] : '0;
    assign cif.iREN      = state_q == FILL;
    assign cif.iaddr     = miss_addr_q;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        if (state_q == IDLE) begin
            if (dcif.imemREN && !hit) begin
                state_d     = FILL;
                miss_addr_d = dcif.imemaddr & ~word_t'(3);
            end
        end else if (!cif.iwait) begin
            // Fill always lands on the latched address, even if the fetch moved on.
            state_d           = IDLE;
            valid_d[miss_idx] = 1'b1;
            tag_d[miss_idx]   = miss_tag;
            data_d[miss_idx]  = cif.iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache with a variable-latency memory model
module tb_icache;
    import cpu_types_pkg::*;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   lat = 2;
    int   cnt = 0;

    datapath_cache_if dcif ();
    caches_if         cif ();

    icache #(.SETS(16), .IDX_W(4)) dut (.CLK(CLK), .nRST(nRST), .dcif(dcif), .cif(cif));

    always #5 CLK = ~CLK;

    function automatic word_t mem_word(word_t a);
        return 32'h2001_0005 ^ {a[23:0], 8'h00};
    endfunction

    // Memory holds iwait high for 'lat' cycles after iREN rises, then returns data for one cycle.
    always @(posedge CLK) cnt <= cif.iREN ? (cnt > 0 ? cnt - 1 : 0) : lat;
    assign cif.iwait = !cif.iREN || cnt != 0;
    assign cif.iload = cif.iwait ? 32'hDEAD_BEEF : mem_word(cif.iaddr);

    task automatic check(string tag, word_t got, word_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(negedge CLK);
        #1;
    endtask

    task automatic drive(logic ren, word_t a);
        dcif.imemREN  = ren;
        dcif.imemaddr = a;
        #1;
    endtask

    task automatic fetch(word_t a, output int cyc);
        drive(1'b1, a);
        cyc = 0;
        while (!dcif.ihit && cyc < 20) begin
            next();
            cyc++;
        end
        check("fetch_done", 32'(dcif.ihit), 1);
    endtask

    initial begin
        int c;
        int r;
        dcif.imemREN  = 1'b0;
        dcif.imemaddr = '0;
        #12;
        check("rst_ihit", 32'(dcif.ihit), 0);
        check("rst_iren", 32'(cif.iREN), 0);
        check("rst_iaddr", cif.iaddr, 0);
        check("rst_imemload", dcif.imemload, 0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;

        drive(1'b1, 32'h0);
        r = 0;
        for (int i = 0; i < 4; i++) begin
            check("fill0_ihit", 32'(dcif.ihit), 0);
            r += int'(cif.iREN);
            next();
        end
        check("fill0_iren_cycles", r, 3);
        check("fill0_ihit_after", 32'(dcif.ihit), 1);
        check("fill0_data", dcif.imemload, 32'h2001_0005);

        lat = 0;
        for (int a = 0; a < 64; a += 4) begin
            fetch(a, c);
            if (a == 4) check("cold_miss_latency", c, 2);
        end
        for (int a = 0; a < 64; a += 4) begin
            drive(1'b1, a);
            check("warm_ihit", 32'(dcif.ihit), 1);
            check("warm_iren", 32'(cif.iREN), 0);
            check("warm_data", dcif.imemload, mem_word(a));
            next();
        end

        fetch(32'h44, c);
        check("conflict_miss", c, 2);
        check("conflict_data", dcif.imemload, mem_word(32'h44));
        fetch(32'h04, c);
        check("conflict_refetch_miss", c, 2);

        fetch(32'h90, c);
        lat = 3;
        drive(1'b1, 32'h10);
        next();
        drive(1'b1, 32'h80);
        r = 0;
        while (cif.iREN && r < 10) begin
            check("midfill_iaddr", cif.iaddr, 32'h10);
            r++;
            next();
        end
        check("midfill_fill_cycles", r, 4);
        check("midfill_new_miss", 32'(dcif.ihit), 0);
        next();
        check("midfill_new_iaddr", cif.iaddr, 32'h80);
        fetch(32'h80, c);
        drive(1'b1, 32'h10);
        check("midfill_frame4_hit", 32'(dcif.ihit), 1);
        check("midfill_frame4_data", dcif.imemload, mem_word(32'h10));

        lat = 5;
        drive(1'b1, 32'hA0);
        next();
        check("rstfill_iren", 32'(cif.iREN), 1);
        next();
        check("rstfill_iwait", 32'(cif.iwait), 1);
        nRST = 1'b0;
        lat = 1;
        #1;
        check("rstfill_iren_drop", 32'(cif.iREN), 0);
        check("rstfill_iaddr", cif.iaddr, 0);
        next();
        nRST = 1'b1;
        drive(1'b1, 32'h10);
        check("rst_cleared_valid", 32'(dcif.ihit), 0);
        fetch(32'hA0, c);
        check("rst_refill_latency", c, 3);
        check("rst_refill_data", dcif.imemload, mem_word(32'hA0));

        lat = 0;
        drive(1'b1, 32'h06);
        check("misal_miss", 32'(dcif.ihit), 0);
        next();
        check("misal_iren", 32'(cif.iREN), 1);
        check("misal_iaddr", cif.iaddr, 32'h04);
        next();
        for (int a = 4; a < 8; a++) begin
            drive(1'b1, a);
            check("misal_hit", 32'(dcif.ihit), 1);
            check("misal_data", dcif.imemload, mem_word(32'h04));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1);
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory controller. It serves `imemload`/`ihit` on `datapath_cache_if` and fills misses one word at a time over the cache–memory port (`iREN`/`iaddr`/`iload`/`iwait`). Hits complete combinationally in the request cycle. Misses stall fetch through `ihit=0` until the frame is filled.

## Interface
- `SETS`, default 16: number of one-word frames; must be a power of 2.
- `IDX_W`, default 4: index width, equal to log2(`SETS`). Tag width is 30−`IDX_W` (26 by default).
- `CLK` in, 1: clock, rising edge.
- `nRST` in, 1: reset, asynchronous, active-low.
- `imemREN` in, 1: datapath fetch request.
- `imemaddr` in, 32: fetch address. Bits [1:0] are ignored.
- `imemload` out, 32: fetched instruction. Valid only while `ihit`=1; otherwise 0.
- `ihit` out, 1: request satisfied this cycle.
- `iREN` out, 1: read request to the memory controller.
- `iaddr` out, 32: fill address, word aligned.
- `iload` in, 32: memory read data, valid when `iwait`=0.
- `iwait` in, 1: memory busy. Low means `iload` is valid this cycle.

## Operation
- Address split: tag = [31:IDX_W+2], idx = [IDX_W+1:2], byte offset = [1:0].
- Each frame holds {valid, tag, data}.
- Hit: `imemREN` & frame[idx].valid & (frame[idx].tag == tag). When hit:
  - `ihit`=1.
  - `imemload`=frame[idx].data.
- FSM state `IDLE`:
  - Hit, or `imemREN`=0: stay in `IDLE`, `iREN`=0.
  - `imemREN`=1 and miss: latch `imemaddr` into `miss_addr` (offset forced to 00) and go to `FILL`. `ihit`=0.
- FSM state `FILL`:
  - `iREN`=1, `iaddr`=`miss_addr`, `ihit`=0.
  - When `iwait`=0: write frame[miss_addr.idx] ← {1, miss_addr.tag, `iload`} and go to `IDLE`.
  - While `iwait`=1: hold in `FILL`.
- A fill evicts unconditionally. There is no write-back, because the contents are read-only.
- `imemaddr` changes during `FILL`: the fill still completes to the latched `miss_addr`. The new address is looked up in `IDLE` on the following cycle.
- `imemREN` drops during `FILL`: the fill still completes, and no hit is reported.
- Data writes are not snooped. Self-modifying code is unsupported.

## Timing
- Reset (asynchronous, `nRST`=0):
  - All valid bits = 0; tags and data = 0.
  - FSM = `IDLE`, `miss_addr` = 0.
  - Outputs: `iREN`=0, `iaddr`=0, `ihit`=0, `imemload`=0.
- Reset asserted mid-`FILL` aborts the fill. No frame is written.
- Hit latency: 0 cycles. `ihit` and `imemload` are combinational from `imemaddr` and the frame array.
- Miss latency, with the memory returning N cycles after `iREN` rises (N ≥ 0 `iwait`-high cycles):
  - Cycle 0: miss detected, move to `FILL`.
  - Cycles 1..N+1: `iREN`=1. The last of these has `iwait`=0 and performs the array write.
  - Cycle N+2: `IDLE`, hit. Total N+2 cycles from miss to `ihit`.
- `iaddr` = `miss_addr` at all times; `iREN` gates its meaning.
- The frame array and FSM update only on a rising `CLK`. There is no combinational path from `iload` to `imemload`.

## Structure
- `cpu_types_pkg` owns:
  - `word_t`.
  - `icachef_t`, a packed struct {tag[25:0], idx[3:0], bytoff[1:0]}.
  - `ITAG_W`=26, `IIDX_W`=4.
- The block-local typedef `icache_state_t` {`IDLE`, `FILL`} also goes in `cpu_types_pkg`, so the cache and memory-controller benches share it.
- The frame array is an inline register array: `SETS`×(1+tag+32) bits, async reset.
- No sub-module. The array and the 2-state FSM sit in one module, connected through `datapath_cache_if.icache` and `caches_if.icache`.

## Test plan
- Reset, then `imemREN`=1, `imemaddr`=0x0000_0000, memory returns 0x2001_0005 with `iwait` high for 2 cycles:
  - `ihit`=0 for 4 cycles; `iREN`=1 for 3 cycles.
  - Then `ihit`=1, `imemload`=0x2001_0005.
- Cold sweep 0x00..0x3C, then the same 16 addresses again: second pass gives `ihit`=1 every cycle with `iREN`=0 throughout.
- Conflict: fill 0x0000_0004, then fetch 0x0000_0044 (same idx 1, tag differs):
  - Miss and refill.
  - Refetching 0x0000_0004 misses again.
- Change `imemaddr` from 0x10 to 0x80 mid-`FILL`:
  - `iaddr` stays 0x10 until `iwait`=0.
  - The next cycle misses on 0x80. Frame 4 holds tag(0x10).
- Assert `nRST` low during `FILL` with `iwait`=1:
  - `iREN`=0 immediately.
  - After release, fetch of the same address misses; no stale valid.
- `imemaddr`=0x0000_0006 (misaligned):
  - `iaddr`=0x0000_0004.
  - Hits thereafter for 0x04 through 0x07.
